// File: rtl/digit_pkg.sv
// rtl/digit_pkg.sv - shared frame geometry, pixel type and loader state encoding
package digit_pkg;

    localparam int IMG_W   = 28;
    localparam int IMG_H   = 28;
    localparam int PIX_W   = 8;
    localparam int NUM_PIX = IMG_W * IMG_H;
    localparam int ADDR_W  = 10;
    localparam int SUM_W   = 18;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } loader_state_t;

endpackage

// File: rtl/frame_pos_counter.sv
// rtl/frame_pos_counter.sv - row/col/linear position of the next pixel within a frame
module frame_pos_counter #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             col_last;
    logic             row_last;

    assign col_last = (col == COL_W'(IMG_W - 1));
    assign row_last = (row == ROW_W'(IMG_H - 1));
    assign last     = col_last && row_last;

    // After the final pixel the position returns to the origin so it never leaves the frame.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (inc) begin
            if (last) begin
                col  <= '0;
                row  <= '0;
                addr <= '0;
            end else begin
                addr <= addr + ADDR_W'(1);
                if (col_last) begin
                    col <= '0;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pixel_frame_loader.sv
// rtl/pixel_frame_loader.sv - assembles one frame of pixels into the image buffer and tracks its intensity sum
module pixel_frame_loader
    import digit_pkg::*;
#(
    parameter int IMG_W  = digit_pkg::IMG_W,
    parameter int IMG_H  = digit_pkg::IMG_H,
    parameter int PIX_W  = digit_pkg::PIX_W,
    parameter int ADDR_W = digit_pkg::ADDR_W,
    parameter int SUM_W  = digit_pkg::SUM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PIX_W-1:0]  pixel_data,
    input  logic              pixel_valid,
    output logic              pixel_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    output logic              frame_done,
    input  logic              frame_ack,
    output logic              busy,
    output logic              overflow,
    output logic [SUM_W-1:0]  pixel_sum
);

    loader_state_t     state;
    logic              accept;
    logic              pos_clear;
    logic              pos_inc;
    logic [ADDR_W-1:0] pos_addr;
    logic              pos_last;

    assign accept    = pixel_valid && pixel_ready;
    // start is honoured in IDLE and LOAD; a pixel offered alongside a restart is dropped.
    assign pos_clear = start && (state != FULL);
    assign pos_inc   = accept && !start && (state == LOAD);

    frame_pos_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_pos (
        .clk   (clk),
        .rst   (rst),
        .clear (pos_clear),
        .inc   (pos_inc),
        .addr  (pos_addr),
        .last  (pos_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pixel_ready <= 1'b0;
            busy        <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
            pixel_sum   <= '0;
        end else begin
            mem_wr_en  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= LOAD;
                        pixel_ready <= 1'b1;
                        busy        <= 1'b1;
                        pixel_sum   <= '0;
                        overflow    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (start) begin
                        pixel_sum <= '0;
                    end else if (accept) begin
                        mem_wr_en <= 1'b1;
                        mem_addr  <= pos_addr;
                        mem_wdata <= pixel_data;
                        pixel_sum <= pixel_sum + SUM_W'(pixel_data);
                        if (pos_last) begin
                            frame_done  <= 1'b1;
                            state       <= FULL;
                            pixel_ready <= 1'b0;
                        end
                    end
                end
                FULL: begin
                    if (pixel_valid) begin
                        overflow <= 1'b1;
                    end
                    // Release wins over a simultaneous start, which is dropped.
                    if (frame_ack) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    pixel_ready <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_frame_loader.sv
// tb/tb_pixel_frame_loader.sv - directed self-checking bench for pixel_frame_loader
module tb_pixel_frame_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pixel_data;
    logic       pixel_valid;
    logic       pixel_ready;
    logic       mem_wr_en;
    logic [9:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       frame_done;
    logic       frame_ack;
    logic       busy;
    logic       overflow;
    logic [17:0] pixel_sum;

    int checks = 0;
    int passed = 0;

    pixel_frame_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .frame_done  (frame_done),
        .frame_ack   (frame_ack),
        .busy        (busy),
        .overflow    (overflow),
        .pixel_sum   (pixel_sum)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached (checks %0d)", checks);
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] pix_val(input int mode, input int a);
        logic [31:0] av;
        av = a;
        case (mode)
            0:       return 8'h01;
            1:       return 8'hFF;
            2:       return av[7:0];
            default: return 8'h02;
        endcase
    endfunction

    // Drives n back-to-back pixels, checking each write one cycle after its accept.
    task automatic feed(input int n, input int base, input int mode, output int bad, output int dones);
        logic [9:0] ea;
        bad = 0;
        dones = 0;
        for (int i = 0; i < n; i++) begin
            pixel_valid = 1'b1;
            pixel_data  = pix_val(mode, base + i);
            @(negedge clk);
            ea = 10'(base + i);
            if (!(mem_wr_en === 1'b1 && mem_addr === ea && mem_wdata === pix_val(mode, base + i))) bad++;
            if (frame_done === 1'b1) begin
                dones++;
                if (base + i != 783) bad++;
            end
        end
        pixel_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_ack();
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pixel_valid = 1'b0; pixel_data = 8'h00; frame_ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({pixel_ready, mem_wr_en, frame_done, busy, overflow} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {pixel_ready, mem_wr_en, frame_done, busy, overflow});
        else passed++;
        checks++;
        if (mem_addr !== 10'd0 || mem_wdata !== 8'd0 || pixel_sum !== 18'd0)
            $display("FAIL reset_data: got addr %0d wdata %0d sum %0d want 0 0 0", mem_addr, mem_wdata, pixel_sum);
        else passed++;
        rst = 1'b0;
        pixel_valid = 1'b1;
        @(negedge clk);
        pixel_valid = 1'b0;
        checks++;
        if (pixel_ready !== 1'b0 || mem_wr_en !== 1'b0 || overflow !== 1'b0)
            $display("FAIL idle_ignore: got ready %b wr %b ovf %b want 0 0 0", pixel_ready, mem_wr_en, overflow);
        else passed++;
    endtask

    task automatic test_ones();
        int bad, dones;
        pulse_start();
        checks++;
        if (pixel_ready !== 1'b1 || busy !== 1'b1 || mem_wr_en !== 1'b0)
            $display("FAIL load_entry: got ready %b busy %b wr %b want 1 1 0", pixel_ready, busy, mem_wr_en);
        else passed++;
        feed(784, 0, 0, bad, dones);
        checks++;
        if (bad !== 0) $display("FAIL ones_writes: got %0d bad writes want 0", bad); else passed++;
        checks++;
        if (dones !== 1) $display("FAIL ones_done: got %0d frame_done pulses want 1", dones); else passed++;
        checks++;
        if (pixel_sum !== 18'd784) $display("FAIL ones_sum: got %0d want 784", pixel_sum); else passed++;
        checks++;
        if (busy !== 1'b1 || pixel_ready !== 1'b0)
            $display("FAIL ones_full: got busy %b ready %b want 1 0", busy, pixel_ready);
        else passed++;
        @(negedge clk);
        checks++;
        if (mem_wr_en !== 1'b0 || frame_done !== 1'b0)
            $display("FAIL ones_quiet: got wr %b done %b want 0 0", mem_wr_en, frame_done);
        else passed++;
        pulse_ack();
        checks++;
        if (busy !== 1'b0) $display("FAIL ones_ack: got busy %b want 0", busy); else passed++;
    endtask

    task automatic test_all_ff();
        int bad, dones;
        pulse_start();
        feed(784, 0, 1, bad, dones);
        checks++;
        if (bad !== 0 || dones !== 1) $display("FAIL ff_writes: got bad %0d dones %0d want 0 1", bad, dones); else passed++;
        checks++;
        if (pixel_sum !== 18'd199920) $display("FAIL ff_sum: got %0d want 199920", pixel_sum); else passed++;
        pixel_valid = 1'b1;
        pixel_data  = 8'h55;
        @(negedge clk);
        pixel_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1 || mem_wr_en !== 1'b0 || pixel_sum !== 18'd199920)
            $display("FAIL ff_overflow: got ovf %b wr %b sum %0d want 1 0 199920", overflow, mem_wr_en, pixel_sum);
        else passed++;
        pulse_start();
        checks++;
        if (busy !== 1'b1 || pixel_ready !== 1'b0 || overflow !== 1'b1)
            $display("FAIL full_start_ignored: got busy %b ready %b ovf %b want 1 0 1", busy, pixel_ready, overflow);
        else passed++;
        pulse_ack();
        checks++;
        if (busy !== 1'b0 || overflow !== 1'b1)
            $display("FAIL ff_ack_sticky: got busy %b ovf %b want 0 1", busy, overflow);
        else passed++;
    endtask

    task automatic test_gapped();
        int bad = 0;
        int dones = 0;
        pulse_start();
        checks++;
        if (overflow !== 1'b0) $display("FAIL gap_ovf_clear: got %b want 0", overflow); else passed++;
        for (int i = 0; i < 784; i++) begin
            pixel_valid = 1'b1;
            pixel_data  = pix_val(2, i);
            @(negedge clk);
            if (!(mem_wr_en === 1'b1 && mem_addr === 10'(i) && mem_wdata === pix_val(2, i))) bad++;
            if (frame_done === 1'b1) begin
                dones++;
                if (i != 783) bad++;
            end
            pixel_valid = 1'b0;
            repeat (2) begin
                @(negedge clk);
                if (mem_wr_en !== 1'b0 || frame_done !== 1'b0) bad++;
            end
        end
        checks++;
        if (bad !== 0 || dones !== 1) $display("FAIL gap_writes: got bad %0d dones %0d want 0 1", bad, dones); else passed++;
        checks++;
        if (pixel_sum !== 18'd98040) $display("FAIL gap_sum: got %0d want 98040", pixel_sum); else passed++;
        pulse_ack();
    endtask

    task automatic test_abort();
        int bad, dones, bad2, dones2;
        pulse_start();
        feed(100, 0, 3, bad, dones);
        checks++;
        if (bad !== 0 || pixel_sum !== 18'd200)
            $display("FAIL abort_pre: got bad %0d sum %0d want 0 200", bad, pixel_sum);
        else passed++;
        start = 1'b1; pixel_valid = 1'b1; pixel_data = 8'h05;
        @(negedge clk);
        start = 1'b0; pixel_valid = 1'b0;
        checks++;
        if (mem_wr_en !== 1'b0 || pixel_sum !== 18'd0 || busy !== 1'b1)
            $display("FAIL abort_restart: got wr %b sum %0d busy %b want 0 0 1", mem_wr_en, pixel_sum, busy);
        else passed++;
        feed(1, 0, 0, bad, dones);
        checks++;
        if (bad !== 0 || mem_addr !== 10'd0 || pixel_sum !== 18'd1)
            $display("FAIL abort_first: got bad %0d addr %0d sum %0d want 0 0 1", bad, mem_addr, pixel_sum);
        else passed++;
        feed(783, 1, 0, bad2, dones2);
        checks++;
        if (bad2 !== 0 || dones + dones2 !== 1 || pixel_sum !== 18'd784)
            $display("FAIL abort_complete: got bad %0d dones %0d sum %0d want 0 1 784", bad2, dones + dones2, pixel_sum);
        else passed++;
        pulse_ack();
    endtask

    task automatic test_rst_mid();
        int bad, dones;
        int idle_bad = 0;
        pulse_start();
        feed(500, 0, 0, bad, dones);
        rst = 1'b1; pixel_valid = 1'b1; pixel_data = 8'h09;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({pixel_ready, mem_wr_en, frame_done, busy, overflow} !== 5'b0 || mem_addr !== 10'd0
            || mem_wdata !== 8'd0 || pixel_sum !== 18'd0)
            $display("FAIL rst_mid: got flags %b addr %0d wdata %0d sum %0d want 00000 0 0 0",
                     {pixel_ready, mem_wr_en, frame_done, busy, overflow}, mem_addr, mem_wdata, pixel_sum);
        else passed++;
        repeat (3) begin
            @(negedge clk);
            if (pixel_ready !== 1'b0 || mem_wr_en !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0)
                idle_bad++;
        end
        pixel_valid = 1'b0;
        checks++;
        if (idle_bad !== 0) $display("FAIL rst_idle: got %0d bad cycles want 0", idle_bad); else passed++;
    endtask

    task automatic test_ack_start();
        int bad, dones;
        pulse_start();
        feed(784, 0, 0, bad, dones);
        pixel_valid = 1'b1;
        @(negedge clk);
        pixel_valid = 1'b0;
        frame_ack = 1'b1; start = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b0 || pixel_ready !== 1'b0 || overflow !== 1'b1)
            $display("FAIL ack_start_idle: got busy %b ready %b ovf %b want 0 0 1", busy, pixel_ready, overflow);
        else passed++;
        pixel_valid = 1'b1; pixel_data = 8'h33;
        @(negedge clk);
        pixel_valid = 1'b0;
        checks++;
        if (mem_wr_en !== 1'b0 || busy !== 1'b0)
            $display("FAIL ack_start_drop: got wr %b busy %b want 0 0", mem_wr_en, busy);
        else passed++;
        pulse_start();
        checks++;
        if (overflow !== 1'b0 || busy !== 1'b1) $display("FAIL new_frame_ovf: got ovf %b busy %b want 0 1", overflow, busy); else passed++;
        feed(2, 0, 2, bad, dones);
        checks++;
        if (bad !== 0 || mem_addr !== 10'd1 || pixel_sum !== 18'd1)
            $display("FAIL new_frame_addr: got bad %0d addr %0d sum %0d want 0 1 1", bad, mem_addr, pixel_sum);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_ones();
        test_all_ff();
        test_gapped();
        test_abort();
        test_rst_mid();
        test_ack_start();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pixel_frame_loader.md
Name: pixel_frame_loader

Overview:
Downstream consumer of the 8-bit pixel holding register. Takes one pixel byte per valid cycle and assembles a 28x28 frame into the image buffer SRAM in row-major order. Keeps a running intensity sum for the normalisation stage. Signals frame completion to the classifier, then holds the buffer until the classifier releases it.

Parameters:
IMG_W, 28, pixels per row
IMG_H, 28, rows per frame
PIX_W, 8, pixel width in bits
ADDR_W, 10, image buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
SUM_W, 18, intensity accumulator width; must satisfy 2^SUM_W > IMG_W*IMG_H*(2^PIX_W-1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle pulse: begin capturing a new frame
pixel_data  in  PIX_W  pixel byte from the holding register output
pixel_valid  in  1  pixel_data holds a new pixel this cycle
pixel_ready  out  1  loader accepts a pixel this cycle
mem_wr_en  out  1  image buffer write strobe
mem_addr  out  ADDR_W  image buffer write address
mem_wdata  out  PIX_W  image buffer write data
frame_done  out  1  single-cycle pulse, coincident with the last write
frame_ack  in  1  classifier releases the buffer
busy  out  1  high in LOAD and FULL
overflow  out  1  sticky: a pixel was offered while in FULL
pixel_sum  out  SUM_W  running sum of pixels accepted in the current frame

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset:
  - state IDLE.
  - pixel_ready, mem_wr_en, frame_done, busy, overflow all 0.
  - mem_addr, mem_wdata, pixel_sum 0; row/col counters 0.
- Accept condition: pixel_valid && pixel_ready.
- States:
  - IDLE
    - pixel_ready=0; pixels offered are ignored; overflow is not set.
    - start -> LOAD. On the same edge: clear row, col, addr counter, pixel_sum and overflow.
  - LOAD
    - pixel_ready=1, busy=1.
    - On each accept:
      - next cycle: mem_wr_en=1, mem_addr=linear counter, mem_wdata=accepted byte.
      - pixel_sum += zero-extended pixel, visible the cycle after accept.
      - col increments; col IMG_W-1 wraps to 0 and row increments.
      - linear counter increments.
    - Write latency is exactly 1 cycle. No write occurs in a cycle without an accept.
    - Accept at row=IMG_H-1, col=IMG_W-1: next cycle does the final write with mem_addr=IMG_W*IMG_H-1 and frame_done=1, and state becomes FULL.
    - start while in LOAD: abort and restart. Counters and pixel_sum clear; a pixel offered in that same cycle is dropped.
  - FULL
    - pixel_ready=0, busy=1, pixel_sum holds.
    - pixel_valid=1 sets overflow (sticky until next start or rst); pixel is dropped.
    - frame_ack -> IDLE.
    - start is ignored in FULL.
- frame_ack in IDLE or LOAD is ignored.
- start and frame_ack both high in FULL: ack wins -> IDLE; start is dropped.
- mem_wr_en is registered and is never high in two cycles without two accepts.
- Counters never exceed frame bounds: no address wraps inside a frame; addresses are 0..783 only.
- rst mid-LOAD: immediate return to IDLE with all reset values. Partial frame is discarded; no frame_done.
- Back-to-back accepts: full throughput, one pixel per cycle, 784 cycles minimum per frame.

Decomposition:
- Shared package (digit_pkg):
  - IMG_W, IMG_H, PIX_W constants.
  - NUM_PIX = IMG_W*IMG_H.
  - pixel_t typedef.
  - loader_state_t enum {IDLE, LOAD, FULL}.
- Natural sub-module: frame_pos_counter. Holds the row/col/linear counter with clear, increment and last-pixel flag outputs. The FSM, write register and accumulator stay in the top.

Test Plan:
- Reset, then start, then 784 consecutive pixels of value 1:
  - addresses 0..783, one per cycle, each 1 cycle after accept.
  - frame_done on the write to address 783; pixel_sum=784; busy stays 1.
- All pixels 0xFF:
  - pixel_sum=199920, no truncation.
  - FULL reached; extra pixel_valid sets overflow=1; no write occurs.
- Valid gapped (1 on, 2 off) with pixel = addr[7:0]:
  - each write's data matches its address.
  - col wraps 27->0 at addr 28; frame_done only on address 783.
- start pulse after 100 accepts in LOAD:
  - next write goes to address 0; pixel_sum restarts from 0; no frame_done for the aborted frame.
- rst asserted at pixel 500:
  - all outputs 0 next cycle; state IDLE; pixels then ignored with pixel_ready=0 and overflow=0.
- In FULL, start and frame_ack high together:
  - goes to IDLE; next pixel_valid is not accepted.
  - a later start begins a new frame at address 0 with overflow cleared.
